// File: rtl/adc_sample_averager.sv
// Moving-average filter over the last 2^LOG2_DEPTH ADC samples with a one-cycle valid strobe.
// Define ADC_AVG_ROUND_EN to round half-up instead of truncating the average.
module adc_sample_averager #(
    parameter int WIDTH      = 12,
    parameter int LOG2_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] avg,
    output logic             avg_valid,
    output logic             filled
);
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SUM_W = WIDTH + LOG2_DEPTH + 1;
    localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);
    localparam logic [LOG2_DEPTH:0] LAST_C  = (LOG2_DEPTH+1)'(DEPTH - 1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]   fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0]      avg_q, avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic                  filled_q, filled_d;
    logic                  mem_we;
    logic [SUM_W-1:0]      oldest, next_sum, avg_full;
    logic                  unused_bits;

    always_comb begin
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        filled_d    = filled_q;
        mem_we      = 1'b0;

        // Until the window is full the slot being overwritten holds no counted sample.
        oldest   = filled_q ? {{(SUM_W-WIDTH){1'b0}}, mem_q[wr_ptr_q]} : '0;
        next_sum = sum_q + {{(SUM_W-WIDTH){1'b0}}, sample} - oldest;
`ifdef ADC_AVG_ROUND_EN
        avg_full = next_sum + ({{(SUM_W-1){1'b0}}, 1'b1} << (LOG2_DEPTH-1));
`else
        avg_full = next_sum;
`endif

        if (flush) begin
            sum_d      = '0;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            filled_d   = 1'b0;
        end else if (sample_valid) begin
            mem_we     = 1'b1;
            sum_d      = next_sum;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            fill_cnt_d = (fill_cnt_q >= LAST_C) ? DEPTH_C : fill_cnt_q + 1'b1;
            if (fill_cnt_q >= LAST_C) begin
                avg_d       = avg_full[LOG2_DEPTH +: WIDTH];
                avg_valid_d = 1'b1;
                filled_d    = 1'b1;
            end
        end
    end

    // The top bit only carries the rounding addend and the low bits are shifted out.
    assign unused_bits = ^{avg_full[SUM_W-1], avg_full[LOG2_DEPTH-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            filled_q    <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            filled_q    <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= sample;
    end

    assign avg       = avg_q;
    assign avg_valid = avg_valid_q;
    assign filled    = filled_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager with a 4-deep window and 12-bit samples.
module tb_adc_sample_averager;
    logic        clk = 1'b0;
    logic        reset, flush, sample_valid;
    logic [11:0] sample;
    logic [11:0] avg;
    logic        avg_valid, filled;
    int          checks = 0;
    int          passes = 0;

    adc_sample_averager #(.WIDTH(12), .LOG2_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .sample(sample),
        .sample_valid(sample_valid), .avg(avg), .avg_valid(avg_valid), .filled(filled)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc(input logic v, input logic [11:0] s, input logic f);
        sample_valid = v;
        sample       = s;
        flush        = f;
        @(posedge clk);
        #1;
    endtask

    task automatic out3(input string tag, input logic [11:0] a, input logic v, input logic fl);
        check({tag, ".avg"}, 32'(avg), 32'(a));
        check({tag, ".avg_valid"}, 32'(avg_valid), 32'(v));
        check({tag, ".filled"}, 32'(filled), 32'(fl));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; sample_valid = 1'b0; sample = '0;
        #1;
        out3("rst_t0", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd55, 1'b0);
        out3("rst_c1", 12'd0, 1'b0, 1'b0);
        cyc(1'b0, 12'd66, 1'b0);
        out3("rst_c2", 12'd0, 1'b0, 1'b0);
        reset = 1'b0;

        cyc(1'b1, 12'd100, 1'b0); out3("warm1", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd200, 1'b0); out3("warm2", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd300, 1'b0); out3("warm3", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd400, 1'b0); out3("first", 12'd250, 1'b1, 1'b1);

        cyc(1'b1, 12'd800, 1'b0); out3("slide800", 12'd425, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 12'(i * 37 + 5), 1'b0);
            out3("idle_hold", 12'd425, 1'b0, 1'b1);
        end
        cyc(1'b1, 12'd0, 1'b0); out3("slide0", 12'd375, 1'b1, 1'b1);

        cyc(1'b1, 12'd1, 1'b0);
        cyc(1'b1, 12'd2, 1'b0);
        cyc(1'b1, 12'd2, 1'b0);
        cyc(1'b1, 12'd2, 1'b0);
`ifdef ADC_AVG_ROUND_EN
        out3("round7", 12'd2, 1'b1, 1'b1);
`else
        out3("trunc7", 12'd1, 1'b1, 1'b1);
`endif
        for (int i = 0; i < 4; i++) cyc(1'b1, 12'hFFF, 1'b0);
        out3("fullscale", 12'hFFF, 1'b1, 1'b1);

        cyc(1'b1, 12'd999, 1'b1); out3("flush_prio", 12'hFFF, 1'b0, 1'b0);
        cyc(1'b1, 12'd10, 1'b0);  out3("post_fl1", 12'hFFF, 1'b0, 1'b0);
        cyc(1'b1, 12'd20, 1'b0);  out3("post_fl2", 12'hFFF, 1'b0, 1'b0);
        cyc(1'b1, 12'd30, 1'b0);  out3("post_fl3", 12'hFFF, 1'b0, 1'b0);
        cyc(1'b1, 12'd40, 1'b0);  out3("post_fl4", 12'd25, 1'b1, 1'b1);

        cyc(1'b0, 12'd0, 1'b1);   out3("flush_idle", 12'd25, 1'b0, 1'b0);
        cyc(1'b1, 12'd5, 1'b0);   out3("mid_w1", 12'd25, 1'b0, 1'b0);
        cyc(1'b1, 12'd5, 1'b0);   out3("mid_w2", 12'd25, 1'b0, 1'b0);
        sample_valid = 1'b0;
        reset = 1'b1;
        #1;
        out3("async_rst", 12'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, 12'd8, 1'b0); out3("rst8_1", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd8, 1'b0); out3("rst8_2", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd8, 1'b0); out3("rst8_3", 12'd0, 1'b0, 1'b0);
        cyc(1'b1, 12'd8, 1'b0); out3("rst8_4", 12'd8, 1'b1, 1'b1);
        cyc(1'b1, 12'd12, 1'b0); out3("b2b", 12'd9, 1'b1, 1'b1);
        cyc(1'b0, 12'd0, 1'b0); out3("pulse_end", 12'd9, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
